// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and payload types for the register-file write-back controller.
package regfile_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned WIDTH      = 32;

  // Register x0 is hard-wired to zero: never written, never busy.
  localparam logic [ADDR_WIDTH-1:0] X0_ADDR = '0;

  // One write-back request: destination register and data.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [WIDTH-1:0]      wd;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bus bundle between execute/memory/decode and the write-back controller.
// Optional macro REGFILE_WB_BYPASS_EN adds the read-port bypass signals.
interface regfile_wb_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = regfile_ctrl_pkg::ADDR_WIDTH,
  parameter int unsigned WIDTH      = regfile_ctrl_pkg::WIDTH
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_wd;
  logic                  alu_ready;

  logic                  ld_issue;
  logic [ADDR_WIDTH-1:0] ld_issue_rd;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_rd;
  logic [WIDTH-1:0]      ld_wd;

  logic [ADDR_WIDTH-1:0] dec_rs1;
  logic [ADDR_WIDTH-1:0] dec_rs2;
  logic [ADDR_WIDTH-1:0] dec_rd;
  logic                  hazard;

  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [WIDTH-1:0]      rf_wd;
  logic                  rf_we;
  logic [NREG-1:0]       busy;

`ifdef REGFILE_WB_BYPASS_EN
  logic [WIDTH-1:0]      rf_rs1_dat;
  logic [WIDTH-1:0]      rf_rs2_dat;
  logic [WIDTH-1:0]      rs1_dat;
  logic [WIDTH-1:0]      rs2_dat;

  modport master (
    output alu_valid, alu_rd, alu_wd, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_wd,
           dec_rs1, dec_rs2, dec_rd, rf_rs1_dat, rf_rs2_dat,
    input  alu_ready, hazard, rf_rd, rf_wd, rf_we, busy, rs1_dat, rs2_dat
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wd, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_wd,
           dec_rs1, dec_rs2, dec_rd, rf_rs1_dat, rf_rs2_dat,
    output alu_ready, hazard, rf_rd, rf_wd, rf_we, busy, rs1_dat, rs2_dat
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_wd, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_wd,
           dec_rs1, dec_rs2, dec_rd,
    input  alu_ready, hazard, rf_rd, rf_wd, rf_we, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wd, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_wd,
           dec_rs1, dec_rs2, dec_rd,
    output alu_ready, hazard, rf_rd, rf_wd, rf_we, busy
  );
`endif

endinterface

// File: rtl/regfile_scoreboard.sv
// Outstanding-load scoreboard: one busy bit per register plus the masked
// decode hazard lookup. x0 is never marked busy.
module regfile_scoreboard #(
  parameter int unsigned ADDR_WIDTH = regfile_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_issue,
  input  logic [ADDR_WIDTH-1:0]        ld_issue_rd,
  input  logic                         ld_valid,
  input  logic [ADDR_WIDTH-1:0]        ld_rd,
  input  logic [ADDR_WIDTH-1:0]        dec_rs1,
  input  logic [ADDR_WIDTH-1:0]        dec_rs2,
  input  logic [ADDR_WIDTH-1:0]        dec_rd,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy,
  output logic                         hazard_c
);

  import regfile_ctrl_pkg::*;

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_RD = ADDR_WIDTH'(X0_ADDR);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector: clear on load return, then set on issue so a newer load wins.
  always_comb begin
    busy_d = busy_q;
    if (ld_valid) begin
      busy_d[ld_rd] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != ZERO_RD)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Decode stalls if any nonzero operand or destination has a pending load.
  always_comb begin
    hazard_c = 1'b0;
    if ((dec_rs1 != ZERO_RD) && busy_q[dec_rs1]) hazard_c = 1'b1;
    if ((dec_rs2 != ZERO_RD) && busy_q[dec_rs2]) hazard_c = 1'b1;
    if ((dec_rd  != ZERO_RD) && busy_q[dec_rd])  hazard_c = 1'b1;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: load-first arbitration of the single
// write port, one-stage registered write, outstanding-load scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN forwards the in-flight write to the
// read operands instead of stalling decode on it.
module regfile_wb_ctrl #(
  parameter int unsigned ADDR_WIDTH = regfile_ctrl_pkg::ADDR_WIDTH,
  parameter int unsigned WIDTH      = regfile_ctrl_pkg::WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  regfile_wb_ctrl_if.slave bus
);

  import regfile_ctrl_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ZERO_RD = ADDR_WIDTH'(X0_ADDR);

  wb_req_t               win;
  logic                  win_vld;
  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_rd_q;
  logic [WIDTH-1:0]      rf_wd_q;
  logic                  sb_hazard_c;

  // Fixed-priority arbiter: a returning load always takes the write port.
  always_comb begin
    win     = '{rd: bus.alu_rd, wd: bus.alu_wd};
    win_vld = bus.alu_valid;
    if (bus.ld_valid) begin
      win     = '{rd: bus.ld_rd, wd: bus.ld_wd};
      win_vld = 1'b1;
    end
  end

  assign bus.alu_ready = !bus.ld_valid;

  // Write stage: capture the winner; writes to x0 are accepted but dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= win_vld && (win.rd != ZERO_RD);
      if (win_vld) begin
        rf_rd_q <= win.rd;
        rf_wd_q <= win.wd;
      end
    end
  end

  assign bus.rf_we = rf_we_q;
  assign bus.rf_rd = rf_rd_q;
  assign bus.rf_wd = rf_wd_q;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_issue    (bus.ld_issue),
    .ld_issue_rd (bus.ld_issue_rd),
    .ld_valid    (bus.ld_valid),
    .ld_rd       (bus.ld_rd),
    .dec_rs1     (bus.dec_rs1),
    .dec_rs2     (bus.dec_rs2),
    .dec_rd      (bus.dec_rd),
    .busy        (bus.busy),
    .hazard_c    (sb_hazard_c)
  );

`ifdef REGFILE_WB_BYPASS_EN
  // Operand bypass: the in-flight write overrides the stale read-port value.
  always_comb begin
    bus.rs1_dat = bus.rf_rs1_dat;
    bus.rs2_dat = bus.rf_rs2_dat;
    if (rf_we_q && (rf_rd_q != ZERO_RD) && (rf_rd_q == bus.dec_rs1)) bus.rs1_dat = rf_wd_q;
    if (rf_we_q && (rf_rd_q != ZERO_RD) && (rf_rd_q == bus.dec_rs2)) bus.rs2_dat = rf_wd_q;
  end

  assign bus.hazard = sb_hazard_c;
`else
  logic wb_hazard_c;

  // Without bypass, a source matching the in-flight write stalls one cycle.
  always_comb begin
    wb_hazard_c = 1'b0;
    if (rf_we_q && (rf_rd_q != ZERO_RD) &&
        ((rf_rd_q == bus.dec_rs1) || (rf_rd_q == bus.dec_rs2))) begin
      wb_hazard_c = 1'b1;
    end
  end

  assign bus.hazard = sb_hazard_c | wb_hazard_c;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: stimulus pushes expected register
// writes (with their cycle), a negedge monitor pops and compares them.
module tb_regfile_wb_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_err;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_wd      = '0;
    bus.ld_issue    = 1'b0;
    bus.ld_issue_rd = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_wd       = '0;
    bus.dec_rs1     = '0;
    bus.dec_rs2     = '0;
    bus.dec_rd      = '0;
`ifdef REGFILE_WB_BYPASS_EN
    bus.rf_rs1_dat  = '0;
    bus.rf_rs2_dat  = '0;
`endif
  endtask

  // Expect a register write from a request accepted at the coming edge.
  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] wd);
    exp_t e;
    e.rd  = rd;
    e.wd  = wd;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Monitor: every write-port pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_err++;
        $display("FAIL wb_missing: rd=%0d expected in cycle %0d, no write by cycle %0d",
                 exp_q[0].rd, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (bus.rf_we) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wb_unexpected: got rd=%0d wd=%h in cycle %0d, required no write",
                   bus.rf_rd, bus.rf_wd, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.rf_rd !== mon_e.rd || bus.rf_wd !== mon_e.wd || cyc != mon_e.cyc) begin
            n_err++;
            $display("FAIL wb_data: got rd=%0d wd=%h cycle %0d, required rd=%0d wd=%h cycle %0d",
                     bus.rf_rd, bus.rf_wd, cyc, mon_e.rd, mon_e.wd, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    cyc      = 0;
    n_checks = 0;
    n_err    = 0;
    idle();

    // Reset state
    #12;
    chk("rst_rf_we",     64'(bus.rf_we),     64'd0);
    chk("rst_rf_rd",     64'(bus.rf_rd),     64'd0);
    chk("rst_rf_wd",     64'(bus.rf_wd),     64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("rst_hazard",    64'(bus.hazard),    64'd0);
    rst_n = 1'b1;
    tick();

    // Plain ALU write-back
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_wd = 32'h0000_1234;
    #1 chk("alu_ready_idle", 64'(bus.alu_ready), 64'd1);
    expect_wb(5'd5, 32'h0000_1234);
    tick();
    idle();

    // Load beats ALU; ALU holds and goes next cycle
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_wd = 32'h0000_0033;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd7; bus.ld_wd  = 32'h0000_CAFE;
    #1 chk("alu_ready_blocked", 64'(bus.alu_ready), 64'd0);
    expect_wb(5'd7, 32'h0000_CAFE);
    tick();
    bus.ld_valid = 1'b0;
    #1 chk("alu_ready_release", 64'(bus.alu_ready), 64'd1);
    expect_wb(5'd3, 32'h0000_0033);
    tick();
    idle();

    // Load-use hazard on rs1
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9;
    tick();
    idle();
    bus.dec_rs1 = 5'd9;
    #1 chk("busy_after_issue", 64'(bus.busy), 64'h200);
    chk("hazard_rs1_busy", 64'(bus.hazard), 64'd1);
    tick();
    chk("hazard_hold", 64'(bus.hazard), 64'd1);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_wd = 32'h0000_0099;
    #1 chk("hazard_ld_return_cycle", 64'(bus.hazard), 64'd1);
    expect_wb(5'd9, 32'h0000_0099);
    tick();
    bus.ld_valid = 1'b0;
    #1 chk("busy_after_return", 64'(bus.busy), 64'h0);
`ifdef REGFILE_WB_BYPASS_EN
    chk("hazard_wb_stage_bypass", 64'(bus.hazard), 64'd0);
`else
    chk("hazard_wb_stage", 64'(bus.hazard), 64'd1);
`endif
    tick();
    chk("hazard_clear", 64'(bus.hazard), 64'd0);
    idle();

    // Issue and return to the same rd: set wins
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd4;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_wd = 32'h0000_0044;
    expect_wb(5'd4, 32'h0000_0044);
    tick();
    idle();
    #1 chk("busy_set_wins", 64'(bus.busy), 64'h10);
    // ALU write to x0 is accepted and dropped
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_wd = 32'h0000_DEAD;
    #1 chk("alu_ready_x0", 64'(bus.alu_ready), 64'd1);
    tick();
    idle();
    #1 chk("rf_we_x0", 64'(bus.rf_we), 64'd0);
    chk("busy_x0_write", 64'(bus.busy), 64'h10);
    bus.dec_rd = 5'd4;
    #1 chk("hazard_dec_rd", 64'(bus.hazard), 64'd1);
    bus.dec_rd = 5'd0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_wd = 32'h0000_4444;
    expect_wb(5'd4, 32'h0000_4444);
    tick();
    idle();
    #1 chk("busy_cleared_4", 64'(bus.busy), 64'h0);

    // Load issue to x0 never marks busy
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd0;
    tick();
    idle();
    #1 chk("busy_x0_issue", 64'(bus.busy), 64'h0);

    // Read of the in-flight write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_wd = 32'h0000_BEEF;
    expect_wb(5'd6, 32'h0000_BEEF);
    tick();
    idle();
    bus.dec_rs2 = 5'd6;
`ifdef REGFILE_WB_BYPASS_EN
    bus.rf_rs1_dat = 32'h0000_2222;
    bus.rf_rs2_dat = 32'h0000_1111;
    #1 chk("hazard_inflight_bypass", 64'(bus.hazard), 64'd0);
    chk("rs2_dat_forward", 64'(bus.rs2_dat), 64'h0000_BEEF);
    chk("rs1_dat_pass",    64'(bus.rs1_dat), 64'h0000_2222);
`else
    #1 chk("hazard_inflight", 64'(bus.hazard), 64'd1);
`endif
    tick();
    chk("hazard_after_inflight", 64'(bus.hazard), 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
    chk("rs2_dat_after", 64'(bus.rs2_dat), 64'h0000_1111);
`endif
    idle();

    // Asynchronous reset mid-operation
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd2;
    tick();
    bus.ld_issue_rd = 5'd9;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_wd = 32'h0000_0088;
    expect_wb(5'd8, 32'h0000_0088);
    tick();
    idle();
    bus.dec_rs1 = 5'd9;
    #1 chk("busy_pre_reset", 64'(bus.busy), 64'h204);
    chk("rf_we_pre_reset", 64'(bus.rf_we), 64'd1);
    chk("hazard_pre_reset", 64'(bus.hazard), 64'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 chk("mid_rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("mid_rst_rf_rd",  64'(bus.rf_rd),  64'd0);
    chk("mid_rst_rf_wd",  64'(bus.rf_wd),  64'd0);
    chk("mid_rst_busy",   64'(bus.busy),   64'd0);
    chk("mid_rst_hazard", 64'(bus.hazard), 64'd0);
    chk("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    idle();

    repeat (3) tick();
    chk("expected_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
